muldiv_sequencer: RTL and testbench

Multi-cycle controller and iterative datapath for the MIPS multiply/divide operations (ALU control codes 4'b0011 mul, 4'b0100 div). The single-cycle ALU does not execute these codes. This block accepts one operation at a time, stalls the pipeline while it iterates, and writes the HI/LO result registers. It sits beside the ALU in EX and is driven by the same 4-bit ALU control word.

---
 rtl/muldiv_sequencer_pkg.sv | 26 ++
 rtl/muldiv_datapath.sv | 63 ++++++
 rtl/muldiv_sequencer.sv | 113 +++++++++++
 tb/tb_muldiv_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: ALU control
// codes and the sequencer state type.
package muldiv_sequencer_pkg;

    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_MUL = 4'b0011;
    localparam logic [3:0] ALUC_DIV = 4'b0100;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;
    localparam logic [3:0] ALUC_NOR = 4'b1100;
    localparam logic [3:0] ALUC_SLL = 4'b1110;
    localparam logic [3:0] ALUC_SRL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] code);
        return (code == ALUC_MUL) || (code == ALUC_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide working registers: one shift-add or one
// restoring-division step per enabled cycle; exposes the post-step value.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             load_div,
    input  logic             step,
    input  logic             step_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    // upper: partial product / partial remainder
    // lower: multiplier shifting out / dividend shifting out, quotient shifting in
    // bop:   multiplicand / divisor
    logic [WIDTH-1:0] upper_q;
    logic [WIDTH-1:0] lower_q;
    logic [WIDTH-1:0] bop_q;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    always_comb begin
        addend    = lower_q[0] ? bop_q : {WIDTH{1'b0}};
        mul_sum   = {1'b0, upper_q} + {1'b0, addend};
        div_shift = {upper_q, lower_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, bop_q};
        // The shifted remainder is always below 2*divisor, so the borrow bit
        // alone tells whether the trial subtraction succeeded.
        div_ge    = ~div_diff[WIDTH];
        if (step_div) begin
            next_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            next_lo = {lower_q[WIDTH-2:0], div_ge};
        end else begin
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], lower_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upper_q <= '0;
            lower_q <= '0;
            bop_q   <= '0;
        end else if (load) begin
            upper_q <= '0;
            lower_q <= load_div ? op_a : op_b;
            bop_q   <= load_div ? op_b : op_a;
        end else if (step) begin
            upper_q <= next_hi;
            lower_q <= next_lo;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS mul/div sequencer: accepts one op from EX, stalls the
// pipeline while the datapath iterates, and writes HI/LO on completion.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           state_dbg
);

    // Handshake: an op is taken on any rising edge in IDLE with start=1,
    // flush=0 and a mul/div code; stall holds the issuer from that same cycle
    // until done, and done is a one-cycle pulse on the HI/LO update.

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] counter;
    logic             accept;
    logic             dz_accept;
    logic             load;
    logic             step;
    logic             last;
    logic             complete;
    logic [WIDTH-1:0] dp_hi;
    logic [WIDTH-1:0] dp_lo;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign accept    = (state == IDLE) && start && !flush && is_muldiv(ALU_control);
    assign dz_accept = accept && (ALU_control == ALUC_DIV) && (op_b == '0);
    assign load      = accept && !dz_accept;
    assign stall     = busy || accept;
    assign step      = busy && !flush;
    assign last      = (counter == LAST_CNT);
    assign complete  = step && last;

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (load) state_nx = (ALU_control == ALUC_DIV) ? DIV : MUL;
                MUL,
                DIV:  if (last) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (flush) begin
                counter <= '0;
            end else if (step) begin
                counter <= last ? '0 : counter + CNT_W'(1);
            end
            // A zero divisor completes on its acceptance edge without iterating.
            if (complete) begin
                hi          <= dp_hi;
                lo          <= dp_lo;
                done        <= 1'b1;
                div_by_zero <= 1'b0;
            end else if (dz_accept) begin
                hi          <= op_a;
                lo          <= '1;
                done        <= 1'b1;
                div_by_zero <= 1'b1;
            end
        end
    end

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_div (ALU_control == ALUC_DIV),
        .step     (step),
        .step_div (state == DIV),
        .op_a     (op_a),
        .op_b     (op_b),
        .next_hi  (dp_hi),
        .next_lo  (dp_lo)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: transaction-level reference model compared every
// cycle, directed scenarios pinned with literal values, then random traffic.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   ctl = ALUC_ADD;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         stall;
    logic         done;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    state_t       state_dbg;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALU_control(ctl),
        .op_a(a), .op_b(b), .flush(flush), .busy(busy), .stall(stall),
        .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / checking ----------------
    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: an accepted op owes its {hi,lo} result WIDTH cycles later.
    logic [2*W-1:0] exp_q[$];
    int             m_rem = 0;
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;
    logic           m_done = 1'b0;
    logic           m_dbz = 1'b0;

    function automatic bit code_ok(input logic [3:0] c);
        return (c == 4'b0011) || (c == 4'b0100);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_rem = 0;
                exp_q.delete();
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = exp_q.pop_front();
                    m_done = 1'b1;
                    m_dbz = 1'b0;
                end
            end else if (start && code_ok(ctl)) begin
                if (ctl == 4'b0100 && b == 0) begin
                    m_hi = a; m_lo = '1; m_done = 1'b1; m_dbz = 1'b1;
                end else begin
                    m_rem = W;
                    if (ctl == 4'b0011) exp_q.push_back(64'(a) * 64'(b));
                    else                exp_q.push_back({a % b, a / b});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  64'(busy),  64'(m_rem > 0));
            check("stall", 64'(stall), 64'((m_rem > 0) || (start && code_ok(ctl) && !flush)));
            check("done",  64'(done),  64'(m_done));
            check("dbz",   64'(dbz),   64'(m_dbz));
            check("hi",    64'(hi),    64'(m_hi));
            check("lo",    64'(lo),    64'(m_lo));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        ctl = c; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        bit seen = 1'b0;
        n = -1;
        for (int i = 1; i <= 200 && !seen; i++) begin
            tick();
            if (done) begin seen = 1'b1; n = i; end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int extra;

        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        rst_n = 1'b1;
        tick();

        // 7 x 6
        issue(ALUC_MUL, 32'd7, 32'd6);
        wait_done(lat);
        check("mul_latency", 64'(lat), 64'd32);
        check("mul_lo", 64'(lo), 64'd42);
        check("mul_hi", 64'(hi), 64'd0);

        // max x max, then div 100/7 issued in the done cycle
        issue(ALUC_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        check("mulmax_hi", 64'(hi), 64'hFFFF_FFFE);
        check("mulmax_lo", 64'(lo), 64'h0000_0001);
        issue(ALUC_DIV, 32'd100, 32'd7);
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'd32);
        check("div_lo", 64'(lo), 64'd14);
        check("div_hi", 64'(hi), 64'd2);

        // divide by zero completes right after acceptance
        issue(ALUC_DIV, 32'h1234, 32'd0);
        check("dz_done", 64'(done), 64'd1);
        check("dz_busy", 64'(busy), 64'd0);
        check("dz_hi",   64'(hi),   64'h1234);
        check("dz_lo",   64'(lo),   64'hFFFF_FFFF);
        check("dz_flag", 64'(dbz),  64'd1);
        tick();
        issue(ALUC_MUL, 32'd3, 32'd3);
        wait_done(lat);
        check("dz_clear", 64'(dbz), 64'd0);
        check("mul33_lo", 64'(lo),  64'd9);

        // flush mid-multiply
        issue(ALUC_MUL, 32'd5, 32'd5);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_lo",   64'(lo),   64'd9);
        extra = 0;
        repeat (40) begin tick(); if (done) extra++; end
        check("flush_no_done", 64'(extra), 64'd0);

        // reset mid-divide
        issue(ALUC_DIV, 32'd1000, 32'd3);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_lo",   64'(lo),   64'd0);
        rst_n = 1'b1;
        tick();

        // non-mul/div code ignored
        ctl = ALUC_ADD; start = 1'b1;
        #1 check("add_stall", 64'(stall), 64'd0);
        tick();
        start = 1'b0;
        check("add_busy", 64'(busy), 64'd0);

        // start while busy ignored
        issue(ALUC_MUL, 32'd11, 32'd13);
        repeat (3) tick();
        issue(ALUC_MUL, 32'd2, 32'd2);
        wait_done(lat);
        check("busy_ign_latency", 64'(lat), 64'd28);
        check("busy_ign_lo", 64'(lo), 64'd143);
        extra = 0;
        repeat (40) begin tick(); if (done) extra++; end
        check("busy_ign_no_extra", 64'(extra), 64'd0);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            flush = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0, 1: ctl = ALUC_MUL;
                2, 3: ctl = ALUC_DIV;
                4:    ctl = ALUC_SUB;
                default: ctl = 4'($urandom_range(0, 15));
            endcase
            a = $urandom();
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 20));
                default: b = $urandom();
            endcase
            tick();
        end
        rst_n = 1'b1; flush = 1'b0; start = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
